// File: rtl/soc_system_pio_pkg.sv
// soc_system_pio_pkg: shared constants for the debounced input PIO
// Provides the register offsets, edge-mode encodings and the EDGE_MODE reset pattern.
package soc_system_pio_pkg;
    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RAW          = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_EDGE_MODE    = 3'd4;
    localparam logic [2:0] ADDR_DEBOUNCE_EN  = 3'd5;
    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;
    // every channel falling-edge: the keys are active-low
    localparam logic [31:0] EDGE_MODE_RST = 32'hAAAA_AAAA;
endpackage

// File: rtl/soc_system_pio_debounce.sv
// soc_system_pio_debounce: one input channel (synchronizer, debounce counter, edge detect)
// Ports: clk, reset_n (async active-low), din (async input), en (debounce enable),
//        sync (synchronised raw), stable (debounced), rise/fall (one-cycle edge flags).
module soc_system_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    input  logic en,
    output logic sync,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0] cnt;
    logic prev;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr     <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], din};
            prev <= stable;
            if (!en) begin
                stable <= sync;
                cnt    <= '0;
            end else if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
    assign sync = sr[SYNC_STAGES-1];
    assign rise = stable & ~prev;
    assign fall = ~stable & prev;
endmodule

// File: rtl/soc_system_debounced_pio.sv
// soc_system_debounced_pio: Avalon-MM input PIO with debounce, edge capture and irq
// Ports: clk, reset_n (async active-low), address/chipselect/write_n/writedata (slave write),
//        in_port (async inputs), readdata (registered, latency 1), irq (level).
module soc_system_debounced_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync, stable, rise, fall, cap_set;
    logic [WIDTH-1:0] irq_mask, edge_cap, debounce_en;
    logic [2*WIDTH-1:0] edge_mode;
    logic [31:0] rd_next;
    logic we;
    logic unused_wd;
    assign we = chipselect && !write_n;
    assign unused_wd = ^writedata;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        soc_system_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_deb (
            .clk(clk),
            .reset_n(reset_n),
            .din(in_port[i]),
            .en(debounce_en[i]),
            .sync(sync[i]),
            .stable(stable[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
        assign cap_set[i] = (rise[i] && (edge_mode[2*i+:2] inside {EDGE_RISE, EDGE_BOTH})) ||
                            (fall[i] && (edge_mode[2*i+:2] inside {EDGE_FALL, EDGE_BOTH}));
    end
    always_comb begin
        rd_next = address == ADDR_DATA         ? 32'(stable)      :
                  address == ADDR_RAW          ? 32'(sync)        :
                  address == ADDR_IRQ_MASK     ? 32'(irq_mask)    :
                  address == ADDR_EDGE_CAPTURE ? 32'(edge_cap)    :
                  address == ADDR_EDGE_MODE    ? 32'(edge_mode)   :
                  address == ADDR_DEBOUNCE_EN  ? 32'(debounce_en) : 32'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask    <= '0;
            edge_cap    <= '0;
            edge_mode   <= EDGE_MODE_RST[2*WIDTH-1:0];
            debounce_en <= '1;
            readdata    <= '0;
        end else begin
            if (we && address == ADDR_IRQ_MASK)    irq_mask    <= writedata[WIDTH-1:0];
            if (we && address == ADDR_EDGE_MODE)   edge_mode   <= writedata[2*WIDTH-1:0];
            if (we && address == ADDR_DEBOUNCE_EN) debounce_en <= writedata[WIDTH-1:0];
            // a new edge is OR-ed in after the clear, so a coinciding set is never lost
            edge_cap <= (edge_cap & ~((we && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0)) | cap_set;
            readdata <= rd_next;
        end
    end
    assign irq = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_soc_system_debounced_pio.sv
// tb_soc_system_debounced_pio: directed self-checking bench for soc_system_debounced_pio
module tb_soc_system_debounced_pio;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    soc_system_debounced_pio #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // both tasks start and end at a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        address    = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic saw;
        vecs[0]  = '{1'b0, 3'd0, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 3'd1, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 3'd2, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 3'd3, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0,         32'hAA};
        vecs[5]  = '{1'b0, 3'd5, 32'h0,         32'hF};
        vecs[6]  = '{1'b0, 3'd6, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 3'd7, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'hFFFF_FFF5, 32'h5};
        vecs[9]  = '{1'b1, 3'd0, 32'hF,         32'h0};
        vecs[10] = '{1'b1, 3'd1, 32'hF,         32'h0};
        vecs[11] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0};
        vecs[12] = '{1'b1, 3'd4, 32'h1234_5678, 32'h78};
        vecs[13] = '{1'b1, 3'd5, 32'hFFFF_FFF0, 32'h0};
        vecs[14] = '{1'b1, 3'd3, 32'hF,         32'h0};
        vecs[15] = '{1'b1, 3'd2, 32'h0,         32'h0};
        vecs[16] = '{1'b1, 3'd4, 32'hAA,        32'hAA};
        vecs[17] = '{1'b1, 3'd5, 32'hF,         32'hF};

        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (2) @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;

        // register map: reset values, RO/unused write protection, width masking
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), r, vecs[i].exp);
        end
        chk("idle_irq", {31'd0, irq}, 32'h0);

        // 5-cycle glitch is visible on RAW
        chipselect = 1'b1; address = 3'd1; in_port[0] = 1'b1; saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 4) in_port[0] = 1'b0;
            saw |= readdata[0];
        end
        chk("glitch_raw_seen", {31'd0, saw}, 32'h1);
        // 7-cycle glitch (one short of the threshold) never reaches DATA
        address = 3'd0; in_port[0] = 1'b1; saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 6) in_port[0] = 1'b0;
            saw |= readdata[0];
        end
        chk("glitch_data_filtered", {31'd0, saw}, 32'h0);

        // held high: stable flips at edge 10, visible on readdata one edge later
        in_port[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_edge10", readdata, 32'h0);
        @(negedge clk);
        chk("held_edge11", readdata, 32'h1);
        chipselect = 1'b0;
        rd(3'd3, r);
        chk("rise_not_captured_default", r, 32'h0);

        // ch1 both edges
        wr(3'd4, 32'h0C);
        wr(3'd2, 32'h2);
        in_port[1] = 1'b1;
        repeat (12) @(negedge clk);
        chk("both_rise_irq", {31'd0, irq}, 32'h1);
        rd(3'd3, r);
        chk("both_rise_cap", r, 32'h2);
        wr(3'd3, 32'h2);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        in_port[1] = 1'b0;
        repeat (12) @(negedge clk);
        rd(3'd3, r);
        chk("both_fall_cap", r, 32'h2);
        wr(3'd3, 32'hF);

        // clear and new edge on ch0 in the same cycle
        wr(3'd4, 32'h0F);
        wr(3'd2, 32'h1);
        in_port[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_coincide_irq", {31'd0, irq}, 32'h1);
        in_port[0] = 1'b1;
        repeat (10) @(negedge clk);
        wr(3'd3, 32'h1);
        chk("coincide_irq", {31'd0, irq}, 32'h1);
        rd(3'd3, r);
        chk("coincide_cap", r, 32'h1);
        wr(3'd3, 32'h1);
        chk("clear_irq", {31'd0, irq}, 32'h0);

        // ch2 undebounced, rising only: 1-cycle pulse captured at edge 4
        wr(3'd5, 32'hB);
        wr(3'd4, 32'h10);
        wr(3'd2, 32'h4);
        wr(3'd3, 32'hF);
        in_port[2] = 1'b1;
        @(negedge clk);
        in_port[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("raw_pulse_edge3_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        chk("raw_pulse_edge4_irq", {31'd0, irq}, 32'h1);
        rd(3'd3, r);
        chk("raw_pulse_cap", r, 32'h4);

        // async reset mid-count while irq is asserted
        in_port[0] = 1'b0;
        repeat (12) @(negedge clk);
        in_port[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_irq", {31'd0, irq}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_irq", {31'd0, irq}, 32'h0);
        chk("async_reset_readdata", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; chipselect = 1'b1; address = 3'd0;
        repeat (10) @(negedge clk);
        chk("restart_edge10", readdata, 32'h0);
        @(negedge clk);
        chk("restart_edge11", readdata, 32'h1);
        chipselect = 1'b0;
        rd(3'd4, r);
        chk("post_reset_mode", r, 32'hAA);
        rd(3'd3, r);
        chk("post_reset_cap", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
